demux14_4_tdm: RTL and testbench

- Registered 1-to-4 demultiplexer for 4-bit words; the receive-side counterpart of the 4:1 4-bit mux.
- Manual mode: routes each valid input word to the output selected by s1,s0.
- TDM mode: deserialises a time-multiplexed stream of 4-word frames (slot 0..3, slot 0 flagged by sync) into four parallel outputs, updated atomically per frame.
- Sits downstream of a select-rotating 4:1 mux link and recovers the four original channels.

---
 rtl/demux14_4_tdm.sv | 149 ++++++++++++++
 tb/tb_demux14_4_tdm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/demux14_4_tdm.sv
// demux14_4_tdm
//   Registered 1-to-4 demultiplexer for WIDTH-bit words. This is the receive
//   side of a select-rotating 4:1 mux link, and it recovers the four channels.
//
//   Manual mode (mode=0): each valid word goes to the output picked by {s1,s0}.
//   TDM mode (mode=1): 4-word frames arrive as slots 0..3. Slot 0 is flagged by
//   sync. Each frame is gathered in shadow registers, and all four outputs are
//   loaded on the same edge when slot 3 arrives.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   mode        0 = manual select, 1 = TDM auto-slot
//   s0, s1      manual select bits (sel = {s1,s0})
//   d           input data word
//   d_valid     d is valid this cycle
//   sync        d is slot 0 of a frame (TDM, sampled only with d_valid)
//   err_clr     synchronous clear of err
//   y0..y3      channel output registers
//   frame_valid one-cycle pulse after y0..y3 load a complete frame
//   slot        next expected slot index (TDM)
//   err         sticky framing error
//
// state | meaning
// IDLE  | not aligned, waiting for a word with sync
// RUN   | aligned, slot_q is the next expected slot
module demux14_4_tdm #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             sync,
  input  logic             err_clr,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d, state_eff;
  logic [1:0]       slot_q, slot_d, slot_eff;
  logic             mode_q;
  logic             err_q, err_d, err_set;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] y_q  [4];
  logic [WIDTH-1:0] y_d  [4];
  logic [WIDTH-1:0] sh_q [3];
  logic [WIDTH-1:0] sh_d [3];
  logic [1:0]       sel;

  assign sel = {s1, s0};

  always_comb begin
    y_d     = y_q;
    sh_d    = sh_q;
    fv_d    = 1'b0;
    err_set = 1'b0;

    // A mode change aborts any partial frame. The word that arrives on the
    // change cycle is still handled under the new mode, so the abort is
    // applied to the state the decode sees and not delayed by one cycle.
    if (mode != mode_q) begin
      state_eff = IDLE;
      slot_eff  = 2'd0;
    end else begin
      state_eff = state_q;
      slot_eff  = slot_q;
    end
    state_d = state_eff;
    slot_d  = slot_eff;

    if (!mode) begin
      state_d = IDLE;
      slot_d  = 2'd0;
      if (d_valid) y_d[sel] = d;
    end else if (d_valid) begin
      if (state_eff == IDLE) begin
        // Words without sync are dropped quietly while unaligned.
        if (sync) begin
          sh_d[0] = d;
          slot_d  = 2'd1;
          state_d = RUN;
        end
      end else if (sync) begin
        // A sync in the middle of a frame throws away the partial frame and
        // starts a new one from this word.
        if (slot_eff != 2'd0) err_set = 1'b1;
        sh_d[0] = d;
        slot_d  = 2'd1;
      end else if (slot_eff == 2'd0) begin
        err_set = 1'b1;
        state_d = IDLE;
      end else if (slot_eff == 2'd3) begin
        y_d[0] = sh_q[0];
        y_d[1] = sh_q[1];
        y_d[2] = sh_q[2];
        y_d[3] = d;
        fv_d   = 1'b1;
        slot_d = 2'd0;
      end else begin
        if (slot_eff == 2'd1) sh_d[1] = d;
        else                  sh_d[2] = d;
        slot_d = slot_eff + 2'd1;
      end
    end

    // When a new error and err_clr arrive together, the new error wins.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      for (int i = 0; i < 4; i++) y_q[i]  <= '0;
      for (int i = 0; i < 3; i++) sh_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mode_q  <= mode;
      err_q   <= err_d;
      fv_q    <= fv_d;
      y_q     <= y_d;
      sh_q    <= sh_d;
    end
  end

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign err         = err_q;

endmodule

// File: tb/tb_demux14_4_tdm.sv
// Testbench for demux14_4_tdm.
// The reference model works on whole frames. It keeps a queue of the words
// gathered since the last sync. Outputs are published when the queue holds
// four words, and the expected slot equals the queue depth.
module tb_demux14_4_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic [3:0] d = '0;
  logic       d_valid = 1'b0, sync = 1'b0, err_clr = 1'b0;
  logic [3:0] y0, y1, y2, y3;
  logic       frame_valid, err;
  logic [1:0] slot;

  int n_chk  = 0;
  int n_fail = 0;

  demux14_4_tdm #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .s0(s0), .s1(s1), .d(d),
    .d_valid(d_valid), .sync(sync), .err_clr(err_clr),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .frame_valid(frame_valid), .slot(slot), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_y [4];
  logic [3:0] q [$];
  logic       m_fv, m_err, synced, m_prev, set_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_y[i] = '0;
      q.delete();
      m_fv = 0; m_err = 0; synced = 0; m_prev = 0;
    end else begin
      set_e = 0;
      m_fv  = 0;
      if (mode != m_prev) begin q.delete(); synced = 0; end
      if (!mode) begin
        q.delete(); synced = 0;
        if (d_valid) m_y[{s1, s0}] = d;
      end else if (d_valid) begin
        if (sync) begin
          if (q.size() > 0) set_e = 1;
          q.delete(); q.push_back(d); synced = 1;
        end else if (q.size() == 0) begin
          if (synced) set_e = 1;
          synced = 0;
        end else begin
          q.push_back(d);
          if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_y[i] = q[i];
            m_fv = 1;
            q.delete();
          end
        end
      end
      m_err  = set_e ? 1'b1 : (err_clr ? 1'b0 : m_err);
      m_prev = mode;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("y0", y0, m_y[0]);
    chk("y1", y1, m_y[1]);
    chk("y2", y2, m_y[2]);
    chk("y3", y3, m_y[3]);
    chk("frame_valid", frame_valid, m_fv);
    chk("slot", slot, q.size());
    chk("err", err, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic md, input logic [1:0] sl, input logic [3:0] dd,
                      input logic v, input logic sy, input logic clr);
    @(negedge clk);
    mode = md; {s1, s0} = sl; d = dd; d_valid = v; sync = sy; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_y(input string nm, input logic [15:0] exp);
    chk(nm, {y0, y1, y2, y3}, exp);
  endtask

  initial begin
    #12;
    chk_y("reset_y", 16'h0000);
    chk("reset_slot", slot, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;

    // Manual routing
    step(0, 2'd0, 4'h0, 1, 0, 0);
    step(0, 2'd1, 4'hF, 1, 0, 0);
    chk("man_y1_lat1", y1, 4'hF);
    step(0, 2'd2, 4'h8, 1, 1, 0);
    step(0, 2'd3, 4'hC, 1, 0, 0);
    chk_y("manual_y", 16'h0F8C);
    chk("man_fv", frame_valid, 0);
    step(0, 2'd0, 4'h5, 0, 0, 0);
    chk_y("manual_hold", 16'h0F8C);

    // TDM frame, back to back
    step(1, 2'd0, 4'h1, 1, 1, 0); chk("tdm_slot1", slot, 1);
    step(1, 2'd0, 4'h2, 1, 0, 0); chk("tdm_slot2", slot, 2);
    step(1, 2'd0, 4'h3, 1, 0, 0); chk("tdm_slot3", slot, 3);
    chk_y("tdm_partial_hidden", 16'h0F8C);
    step(1, 2'd0, 4'h4, 1, 0, 0);
    chk_y("tdm_frame", 16'h1234);
    chk("tdm_fv", frame_valid, 1);
    chk("tdm_slot0", slot, 0);
    step(1, 2'd0, 4'h0, 0, 0, 0);
    chk("tdm_fv_drop", frame_valid, 0);

    // Idle gaps between B and C
    step(1, 2'd0, 4'h5, 1, 1, 0);
    step(1, 2'd0, 4'h6, 1, 0, 0);
    step(1, 2'd0, 4'h0, 0, 0, 0);
    step(1, 2'd0, 4'h0, 0, 0, 0);
    chk("gap_slot", slot, 2);
    step(1, 2'd0, 4'h7, 1, 0, 0);
    chk_y("gap_hold", 16'h1234);
    step(1, 2'd0, 4'h8, 1, 0, 0);
    chk_y("gap_frame", 16'h5678);

    // Early sync on the 3rd word
    step(1, 2'd0, 4'h9, 1, 1, 0);
    step(1, 2'd0, 4'hA, 1, 0, 0);
    step(1, 2'd0, 4'hB, 1, 1, 0);
    chk("early_err", err, 1);
    chk("early_slot", slot, 1);
    chk_y("early_y_held", 16'h5678);
    step(1, 2'd0, 4'hC, 1, 0, 0);
    step(1, 2'd0, 4'hD, 1, 0, 0);
    step(1, 2'd0, 4'hE, 1, 0, 0);
    chk_y("early_frame", 16'hBCDE);
    step(1, 2'd0, 4'h0, 0, 0, 1);
    chk("err_clr", err, 0);

    // Missing sync after a complete frame, with err_clr in the same cycle
    step(1, 2'd0, 4'hF, 1, 0, 1);
    chk("miss_err_prio", err, 1);
    chk("miss_slot", slot, 0);
    step(1, 2'd0, 4'h7, 1, 0, 0);
    chk("idle_drop_slot", slot, 0);
    step(1, 2'd0, 4'h1, 1, 1, 0);
    step(1, 2'd0, 4'h2, 1, 0, 0);
    step(1, 2'd0, 4'h3, 1, 0, 0);
    step(1, 2'd0, 4'h4, 1, 0, 1);
    chk_y("miss_recover", 16'h1234);
    chk("miss_clr", err, 0);

    // Asynchronous reset in the middle of a frame
    step(1, 2'd0, 4'h7, 1, 1, 0);
    step(1, 2'd0, 4'h8, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_y("rst_mid_y", 16'h0000);
    chk("rst_mid_slot", slot, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode toggle aborts a partial frame
    step(1, 2'd0, 4'h9, 1, 1, 0);
    step(1, 2'd0, 4'hA, 1, 0, 1);
    step(1, 2'd0, 4'hB, 1, 0, 0);
    step(1, 2'd0, 4'hC, 1, 0, 0);
    chk_y("pre_abort", 16'h9ABC);
    step(1, 2'd0, 4'h3, 1, 1, 0);
    step(1, 2'd0, 4'h4, 1, 0, 0);
    step(0, 2'd0, 4'h0, 0, 0, 0);
    chk("abort_slot", slot, 0);
    chk("abort_err", err, 0);
    chk_y("abort_y_held", 16'h9ABC);
    step(1, 2'd0, 4'h5, 1, 1, 0);
    step(1, 2'd0, 4'h6, 1, 0, 0);
    step(1, 2'd0, 4'h7, 1, 0, 0);
    step(1, 2'd0, 4'h8, 1, 0, 0);
    chk_y("after_abort", 16'h5678);
    chk("after_abort_err", err, 0);
    step(1, 2'd0, 4'h0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
